// File: rtl/byte_feed_fifo_if.sv
// rtl/byte_feed_fifo_if.sv - producer/consumer signal bundle for byte_feed_fifo
// Producer side : in_data, in_valid, in_ready
// Consumer side : out_en, out_data, out_stb
// Status/control: count, underrun, clr_flags
// Modports      : master (drives producer/consumer requests), slave (the FIFO)
interface byte_feed_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             out_en;
  logic [WIDTH-1:0] out_data;
  logic             out_stb;
  logic [CW-1:0]    count;
  logic             underrun;
  logic             clr_flags;

  modport master (
    output in_data, in_valid, out_en, clr_flags,
    input  in_ready, out_data, out_stb, count, underrun
  );

  modport slave (
    input  in_data, in_valid, out_en, clr_flags,
    output in_ready, out_data, out_stb, count, underrun
  );
endinterface

// File: rtl/byte_feed_fifo.sv
// rtl/byte_feed_fifo.sv - byte FIFO feeding the 8-bit tapped delay line
// clk   : rising-edge clock
// rst_n : asynchronous active-low reset
// bus   : byte_feed_fifo_if.slave
//   in_data/in_valid/in_ready : producer handshake, push = in_valid & in_ready
//   out_en                    : consumer pop request, one byte per enabled clock
//   out_data                  : registered byte, holds last popped value
//   out_stb                   : one-cycle pulse after out_data is updated
//   count                     : occupancy 0..DEPTH
//   underrun/clr_flags        : sticky empty-read flag and its clear
module byte_feed_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  byte_feed_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] out_data_q;
  logic             out_stb_q;
  logic             underrun_q;
  logic             empty;
  logic             push;
  logic             pop;

  // Full/empty come from the occupancy counter; the pointers alone are
  // ambiguous when they are equal.
  assign empty        = (cnt == '0);
  assign bus.in_ready = (cnt != CW'(DEPTH));
  assign push         = bus.in_valid & bus.in_ready;
  // A byte written this cycle is not visible to the read side until the
  // next edge, so an empty FIFO never pops even with a concurrent push.
  assign pop          = bus.out_en & ~empty;

  assign bus.count    = cnt;
  assign bus.out_data = out_data_q;
  assign bus.out_stb  = out_stb_q;
  assign bus.underrun = underrun_q;

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      out_data_q <= '0;
      out_stb_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      out_stb_q <= pop;
      if (pop) begin
        out_data_q <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + AW'(1);
      end

      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase

      // Set has priority over clear so a same-cycle underrun is never lost.
      if (bus.out_en && empty) begin
        underrun_q <= 1'b1;
      end else if (bus.clr_flags) begin
        underrun_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_byte_feed_fifo.sv
// tb/tb_byte_feed_fifo.sv - scoreboard bench for byte_feed_fifo
module tb_byte_feed_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  byte_feed_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  byte_feed_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int stb_seen;
  logic [WIDTH-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must carry the oldest outstanding expected byte.
  always @(negedge clk) begin
    if (rst_n && bus.out_stb) begin
      stb_seen++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL out_data_unexpected: got 0x%0h, expected no strobe", bus.out_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          miscompares++;
          $display("FAIL out_data_order: got 0x%0h, expected 0x%0h", bus.out_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [WIDTH-1:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    exp_q.push_back(b);
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int stb_base;
    vectors      = 0;
    miscompares  = 0;
    stb_seen     = 0;
    rst_n        = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.out_en   = 1'b0;
    bus.clr_flags = 1'b0;
    tick();
    tick();
    check("reset_count", 32'(bus.count), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_data", 32'(bus.out_data), 32'h00);
    check("reset_out_stb", 32'(bus.out_stb), 32'd0);
    check("reset_underrun", 32'(bus.underrun), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: fill three, then drain three
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    check("t1_count3", 32'(bus.count), 32'd3);
    check("t1_in_ready", 32'(bus.in_ready), 32'd1);
    check("t1_out_data_hold", 32'(bus.out_data), 32'h00);
    check("t1_out_stb", 32'(bus.out_stb), 32'd0);
    stb_base = stb_seen;
    bus.out_en = 1'b1;
    tick(); check("t1_pop1", 32'(bus.out_data), 32'h11);
    tick(); check("t1_pop2", 32'(bus.out_data), 32'h22);
    tick(); check("t1_pop3", 32'(bus.out_data), 32'h33);
    bus.out_en = 1'b0;
    check("t1_count0", 32'(bus.count), 32'd0);
    tick();
    check("t1_stb_count", 32'(stb_seen - stb_base), 32'd3);
    check("t1_stb_low", 32'(bus.out_stb), 32'd0);

    // 2: fill to full, fifth byte stalls until a pop
    push_byte(8'hA0);
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    check("t2_full_count", 32'(bus.count), 32'd4);
    check("t2_full_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA4;
    tick();
    check("t2_stall_count", 32'(bus.count), 32'd4);
    bus.out_en = 1'b1;
    tick();
    check("t2_pop_frees", 32'(bus.count), 32'd3);
    check("t2_ready_back", 32'(bus.in_ready), 32'd1);
    exp_q.push_back(8'hA4);
    tick();
    bus.in_valid = 1'b0;
    check("t2_push_pop_count", 32'(bus.count), 32'd3);
    tick(); tick(); tick();
    bus.out_en = 1'b0;
    check("t2_drained", 32'(bus.count), 32'd0);
    check("t2_last", 32'(bus.out_data), 32'hA4);
    tick();

    // 3: steady state at count 2 with one push and one pop per clock
    push_byte(8'h01);
    push_byte(8'h02);
    bus.out_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i + 3);
      exp_q.push_back(8'(i + 3));
      tick();
      check("t3_count_steady", 32'(bus.count), 32'd2);
      check("t3_stb_every", 32'(bus.out_stb), 32'd1);
    end
    bus.in_valid = 1'b0;
    tick(); tick();
    bus.out_en = 1'b0;
    check("t3_drained", 32'(bus.count), 32'd0);
    check("t3_last", 32'(bus.out_data), 32'h0C);
    tick();

    // 4: out_en on empty with a concurrent push
    bus.out_en   = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    exp_q.push_back(8'h5A);
    tick();
    bus.in_valid = 1'b0;
    check("t4_underrun", 32'(bus.underrun), 32'd1);
    check("t4_out_data_hold", 32'(bus.out_data), 32'h0C);
    check("t4_out_stb_low", 32'(bus.out_stb), 32'd0);
    check("t4_count1", 32'(bus.count), 32'd1);
    tick();
    bus.out_en = 1'b0;
    check("t4_out_data", 32'(bus.out_data), 32'h5A);
    check("t4_out_stb", 32'(bus.out_stb), 32'd1);

    // 5: clear, then clear colliding with a new underrun
    bus.clr_flags = 1'b1;
    tick();
    check("t5_cleared", 32'(bus.underrun), 32'd0);
    bus.out_en = 1'b1;
    tick();
    check("t5_set_wins", 32'(bus.underrun), 32'd1);
    bus.out_en    = 1'b0;
    bus.clr_flags = 1'b0;
    tick();

    // 6: asynchronous reset mid-burst
    push_byte(8'hC1);
    push_byte(8'hC2);
    push_byte(8'hC3);
    check("t6_count3", 32'(bus.count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t6_async_count", 32'(bus.count), 32'd0);
    check("t6_async_out_data", 32'(bus.out_data), 32'h00);
    check("t6_async_out_stb", 32'(bus.out_stb), 32'd0);
    check("t6_async_underrun", 32'(bus.underrun), 32'd0);
    check("t6_async_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    push_byte(8'h77);
    bus.out_en = 1'b1;
    tick();
    bus.out_en = 1'b0;
    check("t6_fresh_data", 32'(bus.out_data), 32'h77);
    check("t6_count0", 32'(bus.count), 32'd0);
    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
